timer_io: RTL and testbench
===========================

# timer_io

Memory-mapped 16-bit down-counting timer peripheral that responds on the CPU I/O bus, alongside the LED and switch peripherals. memorio decodes the high address bits into a chip select. The CPU then programs a reload period, a prescaler and a mode through four 16-bit registers. The block counts down, raises a sticky expiry flag and a level interrupt, and toggles a square-wave output on every expiry.

## Interface
- PRESC_W, 8: prescaler field width; fixed at 8 and held in CTRL[15:8].
- clock  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- timercs  in  1  chip select from memorio.
- timerwrite  in  1  write strobe; acts only when timercs=1.
- timerread  in  1  read strobe; acts only when timercs=1.
- timeraddr  in  2  register index: 00 CTRL, 01 PERIOD, 10 COUNT (read-only), 11 STATUS.
- timerwdata  in  16  write data from the CPU (low half of wdata).
- timerrdata  out  16  read data to ioread/memorio.
- timer_irq  out  1  level interrupt, equal to STATUS.DONE & CTRL.IRQEN.
- timer_out  out  1  toggles on each expiry.

## Operation
- CTRL fields: [0] EN, [1] MODE (0 one-shot, 1 periodic), [2] IRQEN, [7:3] reserved (write ignored, read 0), [15:8] PRESC.
- STATUS fields: [0] DONE (sticky), [1] OVR (expiry while DONE already set), [2] RUN (equals EN, read-only), [15:3] read 0.
- Reads are combinational. When timercs & timerread, timerrdata returns the selected register. Otherwise timerrdata = 16'h0000.
- Prescaler counter pcnt runs while EN=1. tick = (pcnt == PRESC). On tick, pcnt ← 0; otherwise pcnt ← pcnt+1.
- Start: a CTRL write with EN going 0→1 loads COUNT ← PERIOD and pcnt ← 0.
- Writing CTRL with EN already 1 updates MODE, IRQEN and PRESC without reloading. A new PRESC applies from the next comparison.
- A CTRL write with EN=0 stops counting. COUNT and pcnt freeze.
- On tick with COUNT≠0: COUNT ← COUNT−1.
- On tick with COUNT=0 (expiry):
  - DONE ← 1, and OVR ← 1 if DONE was already 1; timer_out toggles.
  - Periodic mode: COUNT ← PERIOD.
  - One-shot mode: EN ← 0 and COUNT stays 0.
- Expiry interval is (PERIOD+1)·(PRESC+1) clocks. PERIOD=0 with PRESC=0 expires every clock.
- PERIOD writes do not affect COUNT until the next reload.
- STATUS write is write-1-to-clear on bits [1:0]; other bits are ignored.
- Simultaneous expiry and W1C on the same edge: the set wins for DONE; OVR is evaluated against the pre-clear DONE.
- Simultaneous CTRL write and expiry on the same edge: the CTRL write wins for EN, MODE, IRQEN and PRESC; expiry still sets DONE and toggles timer_out.
- Writes to COUNT (addr 10) are ignored.
- Reset: CTRL=0, PERIOD=0, COUNT=0, pcnt=0, STATUS=0, timer_out=0, timer_irq=0. timerrdata=0 whenever not read-selected.
- Reset asserted mid-count aborts immediately. No pending state survives.

## Timing
- Register writes take effect at the rising clock edge where timercs & timerwrite is high.
- After the EN 0→1 write at edge t:
  - COUNT=PERIOD is visible from edge t.
  - The first tick occurs at edge t+PRESC+1.
  - DONE is set at edge t+(PERIOD+1)(PRESC+1).
- timer_irq is combinational from registered DONE and IRQEN. It is valid in the cycle following the setting edge, with no extra latency.
- Read data is valid in the same cycle as timerread. A read returns the pre-edge register value.
- No handshake or wait states; every access completes in one cycle.

## Structure
- Shared package io_bus_pkg holds:
  - register index constants (REG_CTRL, REG_PERIOD, REG_COUNT, REG_STATUS);
  - CTRL and STATUS bit positions;
  - the I/O data width (16), reused by the leds and switchs blocks.
- One sub-module, timer_prescaler:
  - inputs: clock, reset, en, presc[7:0], clr;
  - output: tick;
  - contains pcnt.
- Register file, down-counter and status logic live in timer_io.

## Test plan
- Reset mid-count: PERIOD=5, PRESC=0, EN=1, then assert reset after 3 clocks → all registers 0, timer_out=0, timer_irq=0; after release, COUNT stays 0 and no expiry occurs.
- One-shot: PERIOD=3, PRESC=1, CTRL=16'h0105 (EN, IRQEN) → DONE and timer_irq rise exactly 8 clocks after the write; RUN reads 0 afterwards; COUNT reads 0; timer_out=1.
- Periodic with overrun: PERIOD=1, PRESC=0, MODE=1 → expiries every 2 clocks; timer_out toggles each time; OVR=1 after the second expiry; writing STATUS=16'h0003 clears both bits.
- W1C vs expiry collision: issue the STATUS=1 write on the expiry edge → DONE remains 1.
- PERIOD rewrite while running: PERIOD=10 running, then write PERIOD=2 → the current period still runs to 10; the next reload uses 2.
- Bus isolation: timercs=0 with timerwrite=1 → no register changes; timerrdata=0; a read of COUNT during counting returns the decrementing value, and a write to COUNT is ignored.

Source files
------------

// File: rtl/io_bus_pkg.sv
// Shared definitions for the CPU I/O bus peripherals.
// Register map and field positions of the timer block.
package io_bus_pkg;

  localparam int IO_DATA_W = 16;
  localparam int PRESC_W   = 8;

  localparam logic [1:0] REG_CTRL   = 2'b00;
  localparam logic [1:0] REG_PERIOD = 2'b01;
  localparam logic [1:0] REG_COUNT  = 2'b10;
  localparam logic [1:0] REG_STATUS = 2'b11;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_MODE      = 1;
  localparam int CTRL_IRQEN     = 2;
  localparam int CTRL_PRESC_LSB = 8;

  localparam int STAT_DONE = 0;
  localparam int STAT_OVR  = 1;
  localparam int STAT_RUN  = 2;

endpackage

// File: rtl/timer_io_if.sv
// Timer register-access bus as driven by memorio.
// Single-cycle access, no wait states.
interface timer_io_if;
  import io_bus_pkg::*;

  logic                 timercs;
  logic                 timerwrite;
  logic                 timerread;
  logic [1:0]           timeraddr;
  logic [IO_DATA_W-1:0] timerwdata;
  logic [IO_DATA_W-1:0] timerrdata;

  modport master (
    output timercs,
    output timerwrite,
    output timerread,
    output timeraddr,
    output timerwdata,
    input  timerrdata
  );

  modport slave (
    input  timercs,
    input  timerwrite,
    input  timerread,
    input  timeraddr,
    input  timerwdata,
    output timerrdata
  );

endinterface

// File: rtl/timer_io_prescaler.sv
// Prescaler: emits one tick every presc+1 enabled clocks.
// clr restarts the division phase on timer start.
module timer_prescaler
  import io_bus_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  input  logic               clr,
  output logic               tick
);

  logic [PRESC_W-1:0] pcnt;

  assign tick = en && (pcnt == presc);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
    end else if (clr) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= tick ? '0 : pcnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/timer_io.sv
// 16-bit down-counting timer on the CPU I/O bus.
// Sticky DONE/OVR status, level irq and square-wave output.
module timer_io
  import io_bus_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  timer_io_if.slave  bus,
  output logic       timer_irq,
  output logic       timer_out
);

  logic                 en;
  logic                 mode;
  logic                 irqen;
  logic [PRESC_W-1:0]   presc;
  logic [IO_DATA_W-1:0] period;
  logic [IO_DATA_W-1:0] count;
  logic                 done;
  logic                 ovr;

  logic                 wr;
  logic                 wr_ctrl;
  logic                 wr_period;
  logic                 wr_status;
  logic                 start;
  logic                 tick;
  logic                 expire;
  logic [IO_DATA_W-1:0] wdata;

  assign wdata     = bus.timerwdata;
  assign wr        = bus.timercs & bus.timerwrite;
  assign wr_ctrl   = wr && (bus.timeraddr == REG_CTRL);
  assign wr_period = wr && (bus.timeraddr == REG_PERIOD);
  assign wr_status = wr && (bus.timeraddr == REG_STATUS);
  assign start     = wr_ctrl && wdata[CTRL_EN] && !en;
  assign expire    = tick && (count == '0);

  timer_prescaler u_presc (
    .clock (clock),
    .reset (reset),
    .en    (en),
    .presc (presc),
    .clr   (start),
    .tick  (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en        <= 1'b0;
      mode      <= 1'b0;
      irqen     <= 1'b0;
      presc     <= '0;
      period    <= '0;
      count     <= '0;
      done      <= 1'b0;
      ovr       <= 1'b0;
      timer_out <= 1'b0;
    end else begin
      // A CTRL write on the expiry edge overrides the one-shot stop
      if (wr_ctrl) begin
        en    <= wdata[CTRL_EN];
        mode  <= wdata[CTRL_MODE];
        irqen <= wdata[CTRL_IRQEN];
        presc <= wdata[CTRL_PRESC_LSB +: PRESC_W];
      end else if (expire && !mode) begin
        en <= 1'b0;
      end
      if (wr_period) begin
        period <= wdata;
      end
      if (start) begin
        count <= period;
      end else if (tick) begin
        if (count != '0) begin
          count <= count - 16'd1;
        end else if (mode) begin
          count <= period;
        end
      end
      // Set beats W1C; OVR looks at DONE before any clear
      done <= expire |
              (done & ~(wr_status & wdata[STAT_DONE]));
      ovr  <= (expire & done) |
              (ovr & ~(wr_status & wdata[STAT_OVR]));
      if (expire) begin
        timer_out <= ~timer_out;
      end
    end
  end

  assign timer_irq = done & irqen;

  always_comb begin
    bus.timerrdata = '0;
    if (bus.timercs && bus.timerread) begin
      unique case (bus.timeraddr)
        REG_CTRL: begin
          bus.timerrdata[CTRL_EN]    = en;
          bus.timerrdata[CTRL_MODE]  = mode;
          bus.timerrdata[CTRL_IRQEN] = irqen;
          bus.timerrdata[CTRL_PRESC_LSB +: PRESC_W] = presc;
        end
        REG_PERIOD: bus.timerrdata = period;
        REG_COUNT:  bus.timerrdata = count;
        REG_STATUS: begin
          bus.timerrdata[STAT_DONE] = done;
          bus.timerrdata[STAT_OVR]  = ovr;
          bus.timerrdata[STAT_RUN]  = en;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_io.sv
// Bench for timer_io: directed scenarios plus randomized runs
// against a closed-form model of the expiry schedule.
module tb_timer_io;
  import io_bus_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic timer_irq;
  logic timer_out;

  timer_io_if bus ();

  timer_io dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus.slave),
    .timer_irq (timer_irq),
    .timer_out (timer_out)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic idle();
    bus.timercs    = 1'b0;
    bus.timerwrite = 1'b0;
    bus.timerread  = 1'b0;
    bus.timeraddr  = 2'b00;
    bus.timerwdata = 16'h0000;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    @(negedge clock);
    bus.timercs    = 1'b1;
    bus.timerwrite = 1'b1;
    bus.timeraddr  = a;
    bus.timerwdata = d;
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] d);
    bus.timercs   = 1'b1;
    bus.timerread = 1'b1;
    bus.timeraddr = a;
    #1;
    d = bus.timerrdata;
    idle();
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  // Expected state c clocks after the start edge, from the
  // (PERIOD+1)*(PRESC+1) expiry schedule.
  function automatic void model(
    input  int         p,
    input  int         s,
    input  int         md,
    input  int         c,
    output int         cnt,
    output logic [2:0] st,
    output logic       out
  );
    int ticks;
    int ex;
    ticks = c / (s + 1);
    if (md != 0) begin
      ex  = ticks / (p + 1);
      cnt = p - (ticks % (p + 1));
    end else if (ticks <= p) begin
      ex  = 0;
      cnt = p - ticks;
    end else begin
      ex  = 1;
      cnt = 0;
    end
    st[STAT_DONE] = (ex >= 1);
    st[STAT_OVR]  = (ex >= 2);
    st[STAT_RUN]  = (md != 0) || (ex == 0);
    out = ex[0];
  endfunction

  task automatic test_reset();
    logic [15:0] d;
    @(negedge clock);
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], d);
      checks++;
      if (d !== 16'h0000) begin
        errors++;
        $display("FAIL reset_reg%0d got %h exp 0000", a, d);
      end
    end
    checks++;
    if (timer_out !== 1'b0 || timer_irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs got %b%b exp 00",
               timer_out, timer_irq);
    end
    reset = 1'b0;
    wr(REG_PERIOD, 16'd5);
    wr(REG_CTRL, 16'h0001);
    step(3);
    @(negedge clock);
    reset = 1'b1;
    #1;
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], d);
      checks++;
      if (d !== 16'h0000) begin
        errors++;
        $display("FAIL midreset_reg%0d got %h exp 0000", a, d);
      end
    end
    checks++;
    if (timer_out !== 1'b0 || timer_irq !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outs got %b%b exp 00",
               timer_out, timer_irq);
    end
    reset = 1'b0;
    step(10);
    @(negedge clock);
    rd(REG_COUNT, d);
    checks++;
    if (d !== 16'h0000) begin
      errors++;
      $display("FAIL postreset_count got %h exp 0000", d);
    end
    rd(REG_STATUS, d);
    checks++;
    if (d !== 16'h0000 || timer_out !== 1'b0) begin
      errors++;
      $display("FAIL postreset_status got %h/%b exp 0000/0",
               d, timer_out);
    end
  endtask

  task automatic test_oneshot();
    logic [15:0] d;
    do_reset();
    wr(REG_PERIOD, 16'd3);
    wr(REG_CTRL, 16'h0105);
    for (int c = 0; c <= 10; c++) begin
      @(negedge clock);
      checks++;
      if (timer_irq !== (c >= 8)) begin
        errors++;
        $display("FAIL oneshot_irq c=%0d got %b exp %b",
                 c, timer_irq, (c >= 8));
      end
      @(posedge clock);
    end
    @(negedge clock);
    rd(REG_STATUS, d);
    checks++;
    if (d !== 16'h0001) begin
      errors++;
      $display("FAIL oneshot_status got %h exp 0001", d);
    end
    rd(REG_COUNT, d);
    checks++;
    if (d !== 16'h0000 || timer_out !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_end got %h/%b exp 0000/1",
               d, timer_out);
    end
  endtask

  task automatic test_periodic_ovr();
    logic [15:0] d;
    do_reset();
    wr(REG_PERIOD, 16'd1);
    wr(REG_CTRL, 16'h0003);
    step(2);
    rd(REG_STATUS, d);
    checks++;
    if (d !== 16'h0005 || timer_out !== 1'b1) begin
      errors++;
      $display("FAIL per_first got %h/%b exp 0005/1",
               d, timer_out);
    end
    step(2);
    rd(REG_STATUS, d);
    checks++;
    if (d !== 16'h0007 || timer_out !== 1'b0) begin
      errors++;
      $display("FAIL per_second got %h/%b exp 0007/0",
               d, timer_out);
    end
    wr(REG_STATUS, 16'h0003);
    rd(REG_STATUS, d);
    checks++;
    if (d !== 16'h0004) begin
      errors++;
      $display("FAIL per_w1c got %h exp 0004", d);
    end
    step(1);
    rd(REG_STATUS, d);
    checks++;
    if (d !== 16'h0005 || timer_out !== 1'b1) begin
      errors++;
      $display("FAIL per_third got %h/%b exp 0005/1",
               d, timer_out);
    end
  endtask

  task automatic test_w1c_collision();
    logic [15:0] d;
    do_reset();
    wr(REG_PERIOD, 16'd1);
    wr(REG_CTRL, 16'h0003);
    step(1);
    wr(REG_STATUS, 16'h0001);
    rd(REG_STATUS, d);
    checks++;
    if (d !== 16'h0005) begin
      errors++;
      $display("FAIL w1c_done got %h exp 0005", d);
    end
    step(1);
    wr(REG_STATUS, 16'h0003);
    rd(REG_STATUS, d);
    checks++;
    if (d !== 16'h0007) begin
      errors++;
      $display("FAIL w1c_ovr got %h exp 0007", d);
    end
  endtask

  task automatic test_period_rewrite();
    logic [15:0] d;
    int          ec;
    logic [15:0] es;
    do_reset();
    wr(REG_PERIOD, 16'd10);
    wr(REG_CTRL, 16'h0003);
    wr(REG_PERIOD, 16'd2);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clock);
      ec = (c <= 10) ? 10 - c : 2 - ((c - 11) % 3);
      es = 16'h0004 | 16'((c >= 11) ? 1 : 0)
                    | 16'((c >= 14) ? 2 : 0);
      rd(REG_COUNT, d);
      checks++;
      if (d !== 16'(ec)) begin
        errors++;
        $display("FAIL rewrite_count c=%0d got %0d exp %0d",
                 c, d, ec);
      end
      rd(REG_STATUS, d);
      checks++;
      if (d !== es) begin
        errors++;
        $display("FAIL rewrite_status c=%0d got %h exp %h",
                 c, d, es);
      end
      @(posedge clock);
    end
  endtask

  task automatic test_bus_isolation();
    logic [15:0] d;
    do_reset();
    @(negedge clock);
    bus.timerwrite = 1'b1;
    bus.timeraddr  = REG_PERIOD;
    bus.timerwdata = 16'h1234;
    @(negedge clock);
    bus.timeraddr  = REG_CTRL;
    bus.timerwdata = 16'h0001;
    @(negedge clock);
    bus.timerread  = 1'b1;
    bus.timeraddr  = REG_PERIOD;
    #1;
    checks++;
    if (bus.timerrdata !== 16'h0000) begin
      errors++;
      $display("FAIL iso_nocs_rdata got %h exp 0000",
               bus.timerrdata);
    end
    idle();
    rd(REG_PERIOD, d);
    checks++;
    if (d !== 16'h0000) begin
      errors++;
      $display("FAIL iso_period got %h exp 0000", d);
    end
    rd(REG_CTRL, d);
    checks++;
    if (d !== 16'h0000) begin
      errors++;
      $display("FAIL iso_ctrl got %h exp 0000", d);
    end
    wr(REG_PERIOD, 16'd6);
    wr(REG_CTRL, 16'h0001);
    step(2);
    rd(REG_COUNT, d);
    checks++;
    if (d !== 16'd4) begin
      errors++;
      $display("FAIL iso_count got %0d exp 4", d);
    end
    bus.timercs   = 1'b1;
    bus.timeraddr = REG_COUNT;
    #1;
    checks++;
    if (bus.timerrdata !== 16'h0000) begin
      errors++;
      $display("FAIL iso_noread got %h exp 0000",
               bus.timerrdata);
    end
    idle();
    wr(REG_COUNT, 16'hffff);
    rd(REG_COUNT, d);
    checks++;
    if (d !== 16'd3) begin
      errors++;
      $display("FAIL iso_countwr got %0d exp 3", d);
    end
  endtask

  task automatic test_random();
    logic [15:0] d;
    logic [15:0] ctrl;
    logic [7:0]  sb;
    logic [2:0]  st;
    logic        out;
    int          p, s, md, ie, n, cnt;
    for (int t = 0; t < 8; t++) begin
      p  = $urandom_range(0, 5);
      s  = $urandom_range(0, 3);
      md = $urandom_range(0, 1);
      ie = $urandom_range(0, 1);
      sb = 8'(s);
      ctrl = {sb, 5'b0, ie[0], md[0], 1'b1};
      do_reset();
      wr(REG_PERIOD, 16'(p));
      wr(REG_CTRL, ctrl);
      n = (p + 1) * (s + 1) * 3 + 2;
      for (int c = 0; c <= n; c++) begin
        @(negedge clock);
        model(p, s, md, c, cnt, st, out);
        rd(REG_COUNT, d);
        checks++;
        if (d !== 16'(cnt)) begin
          errors++;
          $display("FAIL rnd_count t=%0d c=%0d got %0d exp %0d",
                   t, c, d, cnt);
        end
        rd(REG_STATUS, d);
        checks++;
        if (d !== {13'b0, st}) begin
          errors++;
          $display("FAIL rnd_status t=%0d c=%0d got %h exp %h",
                   t, c, d, st);
        end
        checks++;
        if (timer_out !== out ||
            timer_irq !== (st[STAT_DONE] & ie[0])) begin
          errors++;
          $display("FAIL rnd_pins t=%0d c=%0d got %b%b exp %b%b",
                   t, c, timer_out, timer_irq,
                   out, st[STAT_DONE] & ie[0]);
        end
        @(posedge clock);
      end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_oneshot();
    test_periodic_ovr();
    test_w1c_collision();
    test_period_rewrite();
    test_bus_isolation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
